// File: rtl/hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_unit_pkg
//  Brief    : Shared pipeline definitions for the hazard unit: controller
//             state encoding, load-writeback select code, wait-timeout default.
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_unit_pkg;

    // Hazard controller states
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LDUSE    = 2'd1,
        ST_MEMWAIT  = 2'd2,
        ST_REDIRECT = 2'd3
    } hz_state_t;

    // ex_wbsel code selecting data-memory load writeback
    localparam logic [1:0] WB_MEM_DEFAULT = 2'b01;

    // Longest tolerated memory wait, in cycles, before forced release
    localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

    // Width of the memory wait counter and of the stall counter
    localparam int unsigned WAIT_CNT_W  = 16;
    localparam int unsigned STALL_CNT_W = 16;

endpackage : hazard_unit_pkg
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_unit
//  Brief    : Pipeline hazard controller. Detects load-use and memory-wait
//             hazards and PC redirects, drives stall / PC hold / flush, flags
//             memory waits that never complete and counts stalled cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter logic [1:0]  WB_MEM      = WB_MEM_DEFAULT,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active-low
    input  logic [4:0]  id_rs1addr,
    input  logic [4:0]  id_rs2addr,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rdaddr,
    input  logic        ex_regwr,
    input  logic [1:0]  ex_wbsel,
    input  logic        ex_willjmp,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        stall,
    output logic        pc_hold,
    output logic        flush_if,
    output logic        flush_id,
    output logic        mem_timeout,
    output logic [15:0] stall_count
);

    // Counter value at which the current wait cycle is the last tolerated one
    localparam logic [WAIT_CNT_W-1:0] C_TIMEOUT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [STALL_CNT_W-1:0] C_STALL_MAX   = {STALL_CNT_W{1'b1}};

    hz_state_t              state_q, state_d;
    logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic                   mem_timeout_q, mem_timeout_d;
    logic                   release_q, release_d;   // cycle right after a timeout
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    logic w_luh;
    logic w_mw;
    logic w_mw_eff;
    logic w_stall_raw;
    logic w_flush_raw;

    // Hazard detection from the ID/EX/MEM stage signals
    always_comb begin
        w_luh = ex_regwr && (ex_wbsel == WB_MEM) && (ex_rdaddr != 5'd0) &&
                ((id_uses_rs1 && (id_rs1addr == ex_rdaddr)) ||
                 (id_uses_rs2 && (id_rs2addr == ex_rdaddr)));
        w_mw  = mem_req && !mem_ready;
        // The stuck access is abandoned in the release cycle, so its request is ignored
        w_mw_eff = w_mw && !release_q;
    end

    // Next-state, wait counter and raw command decode
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        release_d     = 1'b0;
        w_stall_raw   = 1'b0;
        w_flush_raw   = 1'b0;
        case (state_q)
            ST_RUN, ST_LDUSE: begin
                if (w_mw_eff) begin
                    w_stall_raw = 1'b1;
                    state_d     = ST_MEMWAIT;
                    wait_cnt_d  = WAIT_CNT_W'(1);
                end else if (ex_willjmp) begin
                    w_flush_raw = 1'b1;
                    state_d     = ST_REDIRECT;
                end else if ((state_q == ST_RUN) && w_luh) begin
                    // In LDUSE the EX bubble still carries the load's rd, so luh is masked
                    w_stall_raw = 1'b1;
                    state_d     = ST_LDUSE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_REDIRECT: begin
                // ID holds a squashed slot: only a memory wait matters here
                if (w_mw_eff) begin
                    w_stall_raw = 1'b1;
                    state_d     = ST_MEMWAIT;
                    wait_cnt_d  = WAIT_CNT_W'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEMWAIT: begin
                // EX is frozen, so a pending jump is re-evaluated once back in RUN
                w_stall_raw = 1'b1;
                if (mem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q >= C_TIMEOUT_LAST) begin
                    mem_timeout_d = 1'b1;
                    release_d     = 1'b1;
                    state_d       = ST_RUN;
                    wait_cnt_d    = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Outputs forced low while reset is asserted
    always_comb begin
        stall    = w_stall_raw && rst;
        pc_hold  = w_stall_raw && rst;
        flush_if = w_flush_raw && rst;
        flush_id = w_flush_raw && rst;
    end

    // Saturating count of stalled cycles
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != C_STALL_MAX)) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            release_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            release_q     <= release_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_count = stall_count_q;

endmodule : hazard_unit
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_unit
//  Brief    : Self-checking bench for hazard_unit: table of single-hazard
//             vectors plus directed multi-cycle sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  id_rs1addr = '0;
    logic [4:0]  id_rs2addr = '0;
    logic        id_uses_rs1 = 1'b0;
    logic        id_uses_rs2 = 1'b0;
    logic [4:0]  ex_rdaddr = '0;
    logic        ex_regwr = 1'b0;
    logic [1:0]  ex_wbsel = '0;
    logic        ex_willjmp = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_ready = 1'b0;
    logic        stall, pc_hold, flush_if, flush_id, mem_timeout;
    logic [15:0] stall_count;
    logic [3:0]  dut_out;

    int n_vec  = 0;
    int n_miss = 0;

    hazard_unit #(
        .WB_MEM      (2'b01),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1addr  (id_rs1addr),
        .id_rs2addr  (id_rs2addr),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rdaddr   (ex_rdaddr),
        .ex_regwr    (ex_regwr),
        .ex_wbsel    (ex_wbsel),
        .ex_willjmp  (ex_willjmp),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .stall       (stall),
        .pc_hold     (pc_hold),
        .flush_if    (flush_if),
        .flush_id    (flush_id),
        .mem_timeout (mem_timeout),
        .stall_count (stall_count)
    );

    assign dut_out = {stall, pc_hold, flush_if, flush_id};

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [4:0]  rd;
        logic        regwr;
        logic [1:0]  wbsel;
        logic        jmp;
        logic        mreq;
        logic        mrdy;
        logic [3:0]  exp0;   // {stall,pc_hold,flush_if,flush_id} first cycle out of reset
        logic [3:0]  exp1;   // same, next cycle with inputs held
        logic [15:0] cnt;    // stall_count after both cycles
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        id_rs1addr = '0; id_rs2addr = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rdaddr = '0; ex_regwr = 0; ex_wbsel = '0; ex_willjmp = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic set_luh();
        ex_regwr = 1; ex_wbsel = 2'b01; ex_rdaddr = 5'd5;
        id_rs1addr = 5'd5; id_uses_rs1 = 1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        //            rs1 rs2 u1 u2 rd  wr wbsel  jmp mreq mrdy exp0     exp1     cnt
        vecs[0]  = '{5'd5, 5'd0, 1, 0, 5'd5, 1, 2'b01, 0, 0, 0, 4'b1100, 4'b0000, 16'd1};
        vecs[1]  = '{5'd0, 5'd0, 1, 0, 5'd0, 1, 2'b01, 0, 0, 0, 4'b0000, 4'b0000, 16'd0};
        vecs[2]  = '{5'd3, 5'd7, 0, 1, 5'd7, 1, 2'b01, 0, 0, 0, 4'b1100, 4'b0000, 16'd1};
        vecs[3]  = '{5'd5, 5'd0, 0, 0, 5'd5, 1, 2'b01, 0, 0, 0, 4'b0000, 4'b0000, 16'd0};
        vecs[4]  = '{5'd5, 5'd0, 1, 0, 5'd5, 1, 2'b00, 0, 0, 0, 4'b0000, 4'b0000, 16'd0};
        vecs[5]  = '{5'd5, 5'd0, 1, 0, 5'd5, 0, 2'b01, 0, 0, 0, 4'b0000, 4'b0000, 16'd0};
        vecs[6]  = '{5'd5, 5'd0, 1, 0, 5'd5, 1, 2'b01, 1, 0, 0, 4'b0011, 4'b0000, 16'd0};
        vecs[7]  = '{5'd1, 5'd2, 1, 1, 5'd9, 1, 2'b00, 1, 0, 0, 4'b0011, 4'b0000, 16'd0};
        vecs[8]  = '{5'd5, 5'd0, 1, 0, 5'd5, 1, 2'b01, 1, 1, 0, 4'b1100, 4'b1100, 16'd2};
        vecs[9]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 2'b00, 0, 1, 0, 4'b1100, 4'b1100, 16'd2};
        vecs[10] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 2'b00, 0, 1, 1, 4'b0000, 4'b0000, 16'd0};
        vecs[11] = '{5'd5, 5'd5, 1, 1, 5'd5, 1, 2'b11, 0, 0, 0, 4'b0000, 4'b0000, 16'd0};
        vecs[12] = '{5'd4, 5'd5, 1, 1, 5'd6, 1, 2'b01, 0, 0, 0, 4'b0000, 4'b0000, 16'd0};

        next_cycle();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 13; i++) begin
            rst = 1'b0;
            id_rs1addr = vecs[i].rs1;  id_rs2addr = vecs[i].rs2;
            id_uses_rs1 = vecs[i].u1;  id_uses_rs2 = vecs[i].u2;
            ex_rdaddr = vecs[i].rd;    ex_regwr = vecs[i].regwr;
            ex_wbsel = vecs[i].wbsel;  ex_willjmp = vecs[i].jmp;
            mem_req = vecs[i].mreq;    mem_ready = vecs[i].mrdy;
            #1;
            chk($sformatf("vec%0d_in_reset", i), {12'd0, dut_out}, 16'd0);
            chk($sformatf("vec%0d_cnt_reset", i), stall_count, 16'd0);
            rst = 1'b1;
            #1;
            chk($sformatf("vec%0d_cycle0", i), {12'd0, dut_out}, {12'd0, vecs[i].exp0});
            next_cycle();
            chk($sformatf("vec%0d_cycle1", i), {12'd0, dut_out}, {12'd0, vecs[i].exp1});
            next_cycle();
            chk($sformatf("vec%0d_stall_count", i), stall_count, vecs[i].cnt);
        end

        // ---------------- memory wait, ready after 3 low cycles ----------------
        idle_inputs();
        do_reset();
        mem_req = 1; mem_ready = 0;
        #1;
        chk("mw_c0", {15'd0, stall}, 16'd1);
        next_cycle();
        chk("mw_c1", {12'd0, dut_out}, 16'b1100);
        next_cycle();
        chk("mw_c2", {15'd0, stall}, 16'd1);
        next_cycle();
        mem_ready = 1;
        #1;
        chk("mw_c3_exit", {15'd0, stall}, 16'd1);
        next_cycle();
        mem_req = 0; mem_ready = 0;
        #1;
        chk("mw_after", {12'd0, dut_out}, 16'd0);
        chk("mw_stall_count", stall_count, 16'd4);
        chk("mw_no_timeout", {15'd0, mem_timeout}, 16'd0);

        // ---------------- memory timeout (MEM_TIMEOUT=4) ----------------
        idle_inputs();
        do_reset();
        mem_req = 1; mem_ready = 0;
        #1;
        chk("to_c0", {15'd0, stall}, 16'd1);
        next_cycle();
        chk("to_c1", {15'd0, stall}, 16'd1);
        next_cycle();
        chk("to_c2", {15'd0, stall}, 16'd1);
        next_cycle();
        chk("to_c3", {15'd0, stall}, 16'd1);
        chk("to_flag_c3", {15'd0, mem_timeout}, 16'd0);
        next_cycle();
        chk("to_release", {15'd0, stall}, 16'd0);
        chk("to_flag_set", {15'd0, mem_timeout}, 16'd1);
        chk("to_stall_count", stall_count, 16'd4);
        mem_req = 0;
        next_cycle();
        next_cycle();
        chk("to_flag_sticky", {15'd0, mem_timeout}, 16'd1);
        chk("to_idle", {12'd0, dut_out}, 16'd0);

        // ---------------- reset during MEMWAIT ----------------
        mem_req = 1; mem_ready = 0;
        next_cycle();
        next_cycle();
        chk("rmw_in_wait", {15'd0, stall}, 16'd1);
        rst = 1'b0;
        #1;
        chk("rmw_stall", {15'd0, stall}, 16'd0);
        chk("rmw_count", stall_count, 16'd0);
        chk("rmw_flag", {15'd0, mem_timeout}, 16'd0);
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        chk("rmw_no_residual", {12'd0, dut_out}, 16'd0);

        // ---------------- reset during LDUSE ----------------
        idle_inputs();
        do_reset();
        set_luh();
        #1;
        chk("rlu_luh", {12'd0, dut_out}, 16'b1100);
        next_cycle();
        rst = 1'b0;
        #1;
        chk("rlu_in_reset", {12'd0, dut_out}, 16'd0);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rlu_release", {12'd0, dut_out}, 16'd0);
        next_cycle();
        chk("rlu_no_residual", {12'd0, dut_out}, 16'd0);

        // ---------------- jump/memory interplay across states ----------------
        idle_inputs();
        do_reset();
        set_luh();
        #1;
        chk("seq_luh", {12'd0, dut_out}, 16'b1100);
        next_cycle();
        ex_willjmp = 1;
        #1;
        chk("seq_lduse_jmp", {12'd0, dut_out}, 16'b0011);
        next_cycle();
        ex_willjmp = 0; mem_req = 1; mem_ready = 0;
        #1;
        chk("seq_redirect_mw", {12'd0, dut_out}, 16'b1100);
        next_cycle();
        ex_willjmp = 1;
        #1;
        chk("seq_memwait_jmp_ignored", {12'd0, dut_out}, 16'b1100);
        next_cycle();
        mem_ready = 1;
        #1;
        chk("seq_memwait_exit", {12'd0, dut_out}, 16'b1100);
        next_cycle();
        mem_req = 0; mem_ready = 0;
        #1;
        chk("seq_jmp_reevaluated", {12'd0, dut_out}, 16'b0011);
        chk("seq_stall_count", stall_count, 16'd4);
        idle_inputs();
        next_cycle();
        next_cycle();
        chk("seq_idle", {12'd0, dut_out}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_hazard_unit
`default_nettype wire
